mult_sequencer: RTL

Multi-cycle unsigned 32×32→64 multiplier controller for the MIPS datapath. It implements MIPS `mult`-style hi/lo results without a dedicated multiplier: it sequences the shared 32-bit ALU in ADD mode through a shift-add loop, one multiplier bit per cycle. It sits beside the ALU and drives the ALU operand and select inputs while it is busy.

---
 rtl/mips_alu_pkg.sv | 24 ++
 rtl/mult_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: shared definitions for the MIPS ALU and the multi-cycle
// multiply controller that borrows it.
//   - ALU select encodings (ALU_*)
//   - mult_state_t : multiply sequencer FSM states
//   - MULT_STEPS   : shift-add iterations per product (one per multiplier bit)
package mips_alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_XOR = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b110;
  localparam logic [2:0] ALU_OR  = 3'b111;

  localparam int MULT_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_sequencer.sv
// mult_sequencer: unsigned 32x32->64 multiply controller. Runs a shift-add
// loop through the shared ALU (held in ADD), one multiplier bit per cycle.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start             request pulse, only honoured in IDLE
//   op_a / op_b       multiplicand / multiplier, captured on accepted start
//   busy              controller owns the ALU (RUN state)
//   done              one-cycle pulse, hi/lo valid
//   hi / lo           product [63:32] / [31:0], held between products
//   alu_a/alu_b/alu_sel  ALU operands and select (partial high word, M, ADD)
//   alu_out           combinational ALU result
//
// Optional feature: define MULT_ZERO_BYPASS_EN to finish immediately (hi=lo=0,
// busy never raised) when either operand is zero at start.
module mult_sequencer
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out
);

  localparam int CW = $clog2(MULT_STEPS);
  localparam logic [CW-1:0] LAST = CW'(MULT_STEPS - 1);

  mult_state_t      state_q, state_d;
  logic [WIDTH-1:0] m_q, phi_q, plo_q, hi_q, lo_q;
  logic [WIDTH-1:0] phi_d, plo_d;
  logic [CW-1:0]    cnt_q;
  logic             carry;
  logic             zero_op;

  // Accepted start with a zero operand takes the short path when enabled.
`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (op_a == '0) || (op_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // The ALU has no carry-out; rebuild it from the operand and result MSBs.
  assign carry = (m_q[WIDTH-1] & phi_q[WIDTH-1]) |
                 ((m_q[WIDTH-1] | phi_q[WIDTH-1]) & ~alu_out[WIDTH-1]);

  // One shift-add step: add M when the current multiplier bit is set,
  // then shift the 65-bit {carry, P_hi, P_lo} right by one.
  always_comb begin
    if (plo_q[0]) begin
      phi_d = {carry, alu_out[WIDTH-1:1]};
      plo_d = {alu_out[0], plo_q[WIDTH-1:1]};
    end else begin
      phi_d = {1'b0, phi_q[WIDTH-1:1]};
      plo_d = {phi_q[0], plo_q[WIDTH-1:1]};
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = zero_op ? DONE : RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs (decoded from the state register, so glitch-free)
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= '0;
      phi_q <= '0;
      plo_q <= '0;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          m_q   <= op_a;
          phi_q <= '0;
          plo_q <= op_b;
          cnt_q <= '0;
          if (zero_op) begin
            hi_q <= '0;
            lo_q <= '0;
          end
        end
        RUN: begin
          phi_q <= phi_d;
          plo_q <= plo_d;
          cnt_q <= cnt_q + 1'b1;
          // Result registers take the final step's value as DONE is entered.
          if (cnt_q == LAST) begin
            hi_q <= phi_d;
            lo_q <= plo_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign alu_a   = phi_q;
  assign alu_b   = m_q;
  assign alu_sel = ALU_ADD;

endmodule
